solicitud_peatonal: RTL

SOLICITUD_PEATONAL -- requirements
Module: solicitud_peatonal

---
 rtl/solicitud_peatonal.sv | 135 +++++++++++++
 1 files changed

// File: rtl/solicitud_peatonal.sv
// Pedestrian request conditioner: synchronizer, debounce, press pulse, request latch with blinking wait LED.
// Define SOLICITUD_BLOQUEO_EN to add a post-service lockout (BLOQUEO) after each ack.
module solicitud_peatonal #(
   parameter int FRECUENCIA_RELOJ    = 100_000_000,
   parameter int TIEMPO_REBOTE_MS    = 10,
   parameter int TIEMPO_BLOQUEO_S    = 2,
   parameter int PERIODO_PARPADEO_MS = 500
) (
   input  logic       reloj,
   input  logic       reset,
   input  logic       boton,
   input  logic       ack,
   output logic       solicitud,
   output logic       boton_limpio,
   output logic       pulso_boton,
   output logic       led_espera,
   output logic [7:0] contador_solicitudes
);
   localparam logic [31:0] CICLOS_REBOTE  = 32'(FRECUENCIA_RELOJ / 1000 * TIEMPO_REBOTE_MS);
   localparam logic [31:0] CICLOS_MEDIO   = 32'(FRECUENCIA_RELOJ / 1000 * PERIODO_PARPADEO_MS / 2);
   localparam logic [31:0] CICLOS_BLOQUEO = 32'(FRECUENCIA_RELOJ * TIEMPO_BLOQUEO_S);

   // Terminal-count compares below use N-1, so a zero count would wrap silently.
   if (CICLOS_REBOTE == 0 || CICLOS_MEDIO == 0 || CICLOS_BLOQUEO == 0) begin : g_param_check
      $error("solicitud_peatonal: derived cycle counts must be non-zero");
   end

   typedef enum logic [1:0] {
      REPOSO    = 2'b00,
      PENDIENTE = 2'b01,
      BLOQUEO   = 2'b10
   } estado_t;

   logic        sync_a_reg;
   logic        sync_b_reg;
   logic        limpio_reg;
   logic        limpio_prev_reg;
   logic        pulso_reg;
   logic [31:0] rebote_cnt_reg;
   estado_t     estado_reg;
   estado_t     estado_next;
   logic [7:0]  contador_reg;
   logic        led_reg;
   logic [31:0] parpadeo_cnt_reg;

   always_ff @(posedge reloj) begin
      if (reset) begin
         sync_a_reg      <= 1'b0;
         sync_b_reg      <= 1'b0;
         limpio_reg      <= 1'b0;
         limpio_prev_reg <= 1'b0;
         pulso_reg       <= 1'b0;
         rebote_cnt_reg  <= '0;
      end else begin
         sync_a_reg      <= boton;
         sync_b_reg      <= sync_a_reg;
         limpio_prev_reg <= limpio_reg;
         pulso_reg       <= limpio_reg & ~limpio_prev_reg;
         if (sync_b_reg == limpio_reg) begin
            rebote_cnt_reg <= '0;
         end else if (rebote_cnt_reg == CICLOS_REBOTE - 32'd1) begin
            limpio_reg     <= sync_b_reg;
            rebote_cnt_reg <= '0;
         end else begin
            rebote_cnt_reg <= rebote_cnt_reg + 32'd1;
         end
      end
   end

`ifdef SOLICITUD_BLOQUEO_EN
   logic [31:0] bloqueo_cnt_reg;

   // Held at zero outside BLOQUEO so every lockout starts from a fresh count.
   always_ff @(posedge reloj) begin
      if (reset || estado_reg != BLOQUEO) begin
         bloqueo_cnt_reg <= '0;
      end else begin
         bloqueo_cnt_reg <= bloqueo_cnt_reg + 32'd1;
      end
   end
`endif

   always_ff @(posedge reloj) begin
      if (reset) begin
         estado_reg <= REPOSO;
      end else begin
         estado_reg <= estado_next;
      end
   end

   always_comb begin
      estado_next = REPOSO;
      case (estado_reg)
         REPOSO:    estado_next = pulso_reg ? PENDIENTE : REPOSO;
`ifdef SOLICITUD_BLOQUEO_EN
         PENDIENTE: estado_next = ack ? BLOQUEO : PENDIENTE;
         BLOQUEO:   estado_next = (bloqueo_cnt_reg == CICLOS_BLOQUEO - 32'd1) ? REPOSO : BLOQUEO;
`else
         PENDIENTE: estado_next = ack ? REPOSO : PENDIENTE;
`endif
         default:   estado_next = REPOSO;
      endcase
   end

   // Counting and blinking follow the state transition, so both are registered alongside it.
   always_ff @(posedge reloj) begin
      if (reset) begin
         contador_reg     <= '0;
         led_reg          <= 1'b0;
         parpadeo_cnt_reg <= '0;
      end else begin
         if (estado_reg == REPOSO && pulso_reg && contador_reg != 8'hFF) begin
            contador_reg <= contador_reg + 8'd1;
         end
         if (estado_next != PENDIENTE) begin
            led_reg          <= 1'b0;
            parpadeo_cnt_reg <= '0;
         end else if (estado_reg != PENDIENTE) begin
            led_reg          <= 1'b1;
            parpadeo_cnt_reg <= '0;
         end else if (parpadeo_cnt_reg == CICLOS_MEDIO - 32'd1) begin
            led_reg          <= ~led_reg;
            parpadeo_cnt_reg <= '0;
         end else begin
            parpadeo_cnt_reg <= parpadeo_cnt_reg + 32'd1;
         end
      end
   end

   assign solicitud            = (estado_reg == PENDIENTE);
   assign boton_limpio         = limpio_reg;
   assign pulso_boton          = pulso_reg;
   assign led_espera           = led_reg;
   assign contador_solicitudes = contador_reg;
endmodule
